multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Control unit for the multicycle RV32I datapath. It replaces the single-cycle
//  combinational main decoder with a Moore FSM, plus mem_ready/zero gating.
//  Adds load/store, R-type, JAL/JALR, LUI, BNE and a memory-wait handshake with timeout.
//  Sits between the instruction register (op/funct3) and the shared ALU/memory datapath.
// PARAMETERS
//  MEM_TIMEOUT  15  max consecutive mem_ready=0 cycles in a memory state before TRAP; 0 disables
//  CNT_W        4   width of the wait counter; must hold MEM_TIMEOUT
//  ENABLE_JALR  1   1: op 1100111 executes JALR; 0: op 1100111 is illegal
// PORTS
//  clk        in   1  clock, rising edge
//  rst        in   1  synchronous, active-high reset
//  op         in   7  instruction opcode from the IR
//  funct3     in   3  instruction funct3; bit0 selects BEQ(0)/BNE(1)
//  zero       in   1  ALU zero flag
//  mem_ready  in   1  memory access completes this cycle
//  PCWrite    out  1  PC load enable
//  AdrSrc     out  1  memory address: 0=PC, 1=ALUOut
//  MemWrite   out  1  memory write strobe
//  IRWrite    out  1  IR/OldPC load enable
//  RegWrite   out  1  register file write enable
//  ResultSrc  out  2  00=ALUOut 01=Data 10=ALUResult
//  ALUSrcA    out  2  00=PC 01=OldPC 10=rs1 11=zero
//  ALUSrcB    out  2  00=rs2 01=Imm 10=const 4
//  ALUOp      out  2  00=add 01=sub/compare 10=decode funct fields
//  ImmSrc     out  3  000=I 001=S 010=B 011=J 100=U; decoded from op in every state
//  trap       out  1  sticky; FSM is in TRAP
//  illegal_op out  1  sticky; TRAP was entered through an unknown opcode
//  mem_err    out  1  sticky; TRAP was entered through a memory timeout
// BEHAVIOUR
//  - State register and wait counter update only on the rising edge of clk.
//  - Reset: state<=FETCH, counter<=0, sticky flags<=0.
//  - While rst=1, PCWrite/IRWrite/MemWrite/RegWrite are forced to 0. Other outputs show the FETCH values.
//  - Any output not listed for a state is 0.
//  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10.
//      IRWrite=PCWrite=mem_ready. On mem_ready go to DECODE; otherwise stay.
//  - DECODE: ALUSrcA=01, ALUSrcB=01 (branch/JAL target into ALUOut). Next state by op:
//      0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI.
//      1100011 -> BRANCH; 1101111 -> JAL; 0110111 -> LUI.
//      1100111 -> JALR if ENABLE_JALR, else TRAP.
//      Any other op -> TRAP and set illegal_op.
//  - MEMADR: ALUSrcA=10, ALUSrcB=01. Go to MEMREAD if op=0000011, else MEMWRITE.
//  - MEMREAD: AdrSrc=1. On mem_ready go to MEMWB.
//  - MEMWB: ResultSrc=01, RegWrite=1. Go to FETCH.
//  - MEMWRITE: AdrSrc=1, MemWrite=1 held until mem_ready. On mem_ready go to FETCH.
//  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Go to ALUWB.
//  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Go to ALUWB.
//  - ALUWB: ResultSrc=00, RegWrite=1. Go to FETCH.
//  - BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01.
//      PCWrite = zero XOR funct3[0]. Go to FETCH.
//  - JALR: ALUSrcA=10, ALUSrcB=01. Go to JAL (target into ALUOut).
//  - JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1. Go to ALUWB (rd<=OldPC+4).
//  - LUI: ALUSrcA=11, ALUSrcB=01. Go to ALUWB.
//  - TRAP: all enables 0, trap=1. Exit only through rst.
//  - Wait counter:
//      Counts cycles in FETCH/MEMREAD/MEMWRITE with mem_ready=0.
//      Clears on mem_ready=1 or on entering any state.
//      Does not count when MEM_TIMEOUT=0.
//      If mem_ready=0 and counter==MEM_TIMEOUT-1: go to TRAP and set mem_err.
//  - mem_ready=1 on the timeout cycle completes the access. No trap.
//  - Latency at mem_ready=1 every cycle:
//      R/I-type 4 cycles, load 5, store 4, branch 3, JAL 4, JALR 5, LUI 4.
// TESTING
//  - rst=1 for 2 cycles, mem_ready=1 -> all enables 0 during reset; next cycle IRWrite=PCWrite=1, ALUSrcB=10.
//  - op=0000011, mem_ready=0 for 3 cycles in MEMREAD -> AdrSrc=1 held 3 cycles; MEMWB RegWrite=1, ResultSrc=01.
//  - op=1100011, funct3=001: zero=0 -> PCWrite=1 in BRANCH; zero=1 -> PCWrite=0. Back in FETCH next cycle.
//  - op=1100111, ENABLE_JALR=1 -> DECODE,JALR,JAL(PCWrite=1),ALUWB(RegWrite=1); ENABLE_JALR=0 -> trap=1, illegal_op=1.
//  - mem_ready held 0 in FETCH, MEM_TIMEOUT=15 -> trap=1, mem_err=1 after 15 cycles; mem_ready on cycle 15 -> no trap.
//  - op=0100011, mem_ready=1 on 2nd MEMWRITE cycle -> MemWrite=1 for exactly 2 cycles; RegWrite never asserted.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Purpose : Moore control FSM for the multicycle RV32I datapath, with memory-wait timeout and sticky trap flags.
// Latency : R/I-type 4 cycles, load 5, store 4, branch 3, JAL 4, JALR 5, LUI 4 (mem_ready=1 every cycle).
// Backpr. : FETCH/MEMREAD/MEMWRITE stall until mem_ready=1; MEM_TIMEOUT stalled cycles in a row -> TRAP.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   op, funct3         opcode and funct3 from the IR (funct3[0] selects BEQ/BNE)
//   zero, mem_ready    ALU zero flag, memory access completes this cycle
//   PCWrite..ImmSrc    datapath controls (Moore, except the mem_ready/zero gating)
//   trap, illegal_op,
//   mem_err            sticky status: in TRAP, entered by bad opcode, entered by memory timeout
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4,
  parameter bit ENABLE_JALR = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       trap,
  output logic       illegal_op,
  output logic       mem_err
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JALR     = 4'd10;
  localparam logic [3:0] S_JAL      = 4'd11;
  localparam logic [3:0] S_LUI      = 4'd12;
  localparam logic [3:0] S_TRAP     = 4'd13;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, mem_err_q;
  logic             set_illegal, set_mem_err;
  logic             is_wait, timeout;
  logic [3:0]       out_state;
  logic             unused_funct3;

  assign unused_funct3 = ^funct3[2:1];

  assign is_wait = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
  // mem_ready=1 on the last allowed cycle still completes the access.
  assign timeout = (MEM_TIMEOUT != 0) && is_wait && !mem_ready && (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    set_illegal = 1'b0;
    set_mem_err = 1'b0;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXECR;
          7'b0010011:             state_d = S_EXECI;
          7'b1100011:             state_d = S_BRANCH;
          7'b1101111:             state_d = S_JAL;
          7'b0110111:             state_d = S_LUI;
          7'b1100111: begin
            if (ENABLE_JALR) begin
              state_d = S_JALR;
            end else begin
              state_d     = S_TRAP;
              set_illegal = 1'b1;
            end
          end
          default: begin
            state_d     = S_TRAP;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR:   state_d = (op == 7'b0000011) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JALR:     state_d = S_JAL;
      S_JAL:      state_d = S_ALUWB;
      S_LUI:      state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase
    if (timeout) begin
      state_d     = S_TRAP;
      set_mem_err = 1'b1;
    end
  end

  // Counter only runs while a memory-facing state is stalled in place.
  always_comb begin
    if ((MEM_TIMEOUT == 0) || !is_wait || mem_ready || (state_d != state_q)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (set_illegal) illegal_q <= 1'b1;
      if (set_mem_err) mem_err_q <= 1'b1;
    end
  end

  // During reset the outputs look like FETCH with every enable held low.
  assign out_state = rst ? S_FETCH : state_q;

  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    case (out_state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      S_DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
      S_MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB:    begin ResultSrc = 2'b01; RegWrite = 1'b1; end
      S_MEMWRITE: begin AdrSrc = 1'b1; MemWrite = 1'b1; end
      S_EXECR:    begin ALUSrcA = 2'b10; ALUSrcB = 2'b00; ALUOp = 2'b10; end
      S_EXECI:    begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUOp = 2'b10; end
      S_ALUWB:    RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        PCWrite = zero ^ funct3[0];
      end
      S_JALR:     begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      S_JAL:      begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; PCWrite = 1'b1; end
      S_LUI:      begin ALUSrcA = 2'b11; ALUSrcB = 2'b01; end
      default: ;
    endcase
    if (rst) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

  // Immediate format follows the opcode regardless of state.
  always_comb begin
    case (op)
      7'b0100011: ImmSrc = 3'b001;
      7'b1100011: ImmSrc = 3'b010;
      7'b1101111: ImmSrc = 3'b011;
      7'b0110111: ImmSrc = 3'b100;
      default:    ImmSrc = 3'b000;
    endcase
  end

  assign trap       = (out_state == S_TRAP);
  assign illegal_op = illegal_q & ~rst;
  assign mem_err    = mem_err_q & ~rst;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = 7'b0000011;
  logic [2:0] funct3 = 3'b000;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;

  logic       pcw1, adr1, mw1, irw1, rw1, tr1, il1, me1;
  logic [1:0] rs1, sa1, sb1, aop1;
  logic [2:0] imm1;
  logic       pcw0, adr0, mw0, irw0, rw0, tr0, il0, me0;
  logic [1:0] rs0, sa0, sb0, aop0;
  logic [2:0] imm0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.MEM_TIMEOUT(15), .CNT_W(4), .ENABLE_JALR(1'b1)) u_dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(pcw1), .AdrSrc(adr1), .MemWrite(mw1), .IRWrite(irw1), .RegWrite(rw1),
    .ResultSrc(rs1), .ALUSrcA(sa1), .ALUSrcB(sb1), .ALUOp(aop1), .ImmSrc(imm1),
    .trap(tr1), .illegal_op(il1), .mem_err(me1)
  );

  multicycle_control_fsm #(.MEM_TIMEOUT(15), .CNT_W(4), .ENABLE_JALR(1'b0)) u_dut_nojalr (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(pcw0), .AdrSrc(adr0), .MemWrite(mw0), .IRWrite(irw0), .RegWrite(rw0),
    .ResultSrc(rs0), .ALUSrcA(sa0), .ALUSrcB(sb0), .ALUOp(aop0), .ImmSrc(imm0),
    .trap(tr0), .illegal_op(il0), .mem_err(me0)
  );

  logic [18:0] out1, out0;
  assign out1 = {pcw1, adr1, mw1, irw1, rw1, rs1, sa1, sb1, aop1, imm1, tr1, il1, me1};
  assign out0 = {pcw0, adr0, mw0, irw0, rw0, rs0, sa0, sb0, aop0, imm0, tr0, il0, me0};

  typedef struct {
    logic [18:0] e1;
    logic        c1;
    logic [18:0] e0;
    logic        c0;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,ImmSrc,trap,illegal_op,mem_err}
  function automatic logic [18:0] v(input logic pcw, adr, mw, irw, rw,
                                    input logic [1:0] rs, sa, sb, aop,
                                    input logic [2:0] imm, input logic tr, il, me);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, aop, imm, tr, il, me};
  endfunction

  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, BR = 7'b1100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, LU = 7'b0110111, JR = 7'b1100111;

  // Drive one cycle of inputs and queue the outputs expected for that cycle.
  task automatic step(input logic r, input logic [6:0] o, input logic [2:0] f3, input logic z,
                      input logic mr, input logic [18:0] e1, input logic c1,
                      input logic [18:0] e0, input logic c0, input string nm);
    exp_t e;
    rst = r; op = o; funct3 = f3; zero = z; mem_ready = mr;
    e.e1 = e1; e.c1 = c1; e.e0 = e0; e.c0 = c0; e.nm = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are settled mid-cycle, compare against the oldest expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.c1) begin
        checks++;
        if (out1 !== e.e1) begin
          errors++;
          $display("FAIL %s (jalr dut): got %b expected %b", e.nm, out1, e.e1);
        end
      end
      if (e.c0) begin
        checks++;
        if (out0 !== e.e0) begin
          errors++;
          $display("FAIL %s (nojalr dut): got %b expected %b", e.nm, out0, e.e0);
        end
      end
    end
  end

  initial begin
    logic [18:0] x;
    logic [18:0] trp;
    @(posedge clk);
    #1;
    // Reset: enables low, FETCH datapath selects.
    x = v(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0,0);
    step(1, LD, 3'b000, 0, 1, x, 1, x, 1, "reset_c1");
    step(1, LD, 3'b000, 0, 1, x, 1, x, 1, "reset_c2");
    x = v(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0,0);
    step(0, LD, 3'b000, 0, 1, x, 1, x, 1, "fetch_after_reset");
    // Load with three stalled MEMREAD cycles.
    step(0, LD, 3'b000, 0, 1, v(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0,0), 1, x, 0, "decode_ld");
    step(0, LD, 3'b000, 0, 1, v(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0,0,0), 1, x, 0, "memadr_ld");
    for (int i = 0; i < 3; i++)
      step(0, LD, 3'b000, 0, 0, v(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0,0), 1, x, 0, "memread_wait");
    step(0, LD, 3'b000, 0, 1, v(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0,0), 1, x, 0, "memread_done");
    step(0, LD, 3'b000, 0, 1, v(0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000,0,0,0), 1, x, 0, "memwb");
    // Store, ready on the second MEMWRITE cycle.
    step(0, ST, 3'b000, 0, 1, v(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b001,0,0,0), 1, x, 0, "fetch_st");
    step(0, ST, 3'b000, 0, 1, v(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b001,0,0,0), 1, x, 0, "decode_st");
    step(0, ST, 3'b000, 0, 1, v(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b001,0,0,0), 1, x, 0, "memadr_st");
    step(0, ST, 3'b000, 0, 0, v(0,1,1,0,0,2'b00,2'b00,2'b00,2'b00,3'b001,0,0,0), 1, x, 0, "memwrite_c1");
    step(0, ST, 3'b000, 0, 1, v(0,1,1,0,0,2'b00,2'b00,2'b00,2'b00,3'b001,0,0,0), 1, x, 0, "memwrite_c2");
    // BNE taken (zero=0) then not taken (zero=1).
    step(0, BR, 3'b001, 0, 1, v(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b010,0,0,0), 1, x, 0, "fetch_bne1");
    step(0, BR, 3'b001, 0, 1, v(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b010,0,0,0), 1, x, 0, "decode_bne1");
    step(0, BR, 3'b001, 0, 1, v(1,0,0,0,0,2'b00,2'b10,2'b00,2'b01,3'b010,0,0,0), 1, x, 0, "bne_taken");
    step(0, BR, 3'b001, 1, 1, v(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b010,0,0,0), 1, x, 0, "fetch_bne2");
    step(0, BR, 3'b001, 1, 1, v(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b010,0,0,0), 1, x, 0, "decode_bne2");
    step(0, BR, 3'b001, 1, 1, v(0,0,0,0,0,2'b00,2'b10,2'b00,2'b01,3'b010,0,0,0), 1, x, 0, "bne_not_taken");
    // R-type.
    step(0, RT, 3'b000, 0, 1, v(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0,0), 1, x, 0, "fetch_after_branch");
    step(0, RT, 3'b000, 0, 1, v(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0,0), 1, x, 0, "decode_r");
    step(0, RT, 3'b000, 0, 1, v(0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b000,0,0,0), 1, x, 0, "execr");
    step(0, RT, 3'b000, 0, 1, v(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0,0,0), 1, x, 0, "aluwb_r");
    // LUI.
    step(0, LU, 3'b000, 0, 1, v(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b100,0,0,0), 1, x, 0, "fetch_lui");
    step(0, LU, 3'b000, 0, 1, v(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b100,0,0,0), 1, x, 0, "decode_lui");
    step(0, LU, 3'b000, 0, 1, v(0,0,0,0,0,2'b00,2'b11,2'b01,2'b00,3'b100,0,0,0), 1, x, 0, "lui");
    step(0, LU, 3'b000, 0, 1, v(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b100,0,0,0), 1, x, 0, "aluwb_lui");
    // FETCH stalls 14 cycles, ready on the 15th: no trap; then I-type.
    for (int i = 0; i < 14; i++)
      step(0, IT, 3'b000, 0, 0, v(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0,0), 1, x, 0, "fetch_wait14");
    step(0, IT, 3'b000, 0, 1, v(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0,0), 1, x, 0, "fetch_ready_c15");
    step(0, IT, 3'b000, 0, 1, v(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0,0), 1, x, 0, "decode_i");
    step(0, IT, 3'b000, 0, 1, v(0,0,0,0,0,2'b00,2'b10,2'b01,2'b10,3'b000,0,0,0), 1, x, 0, "execi");
    step(0, IT, 3'b000, 0, 1, v(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0,0,0), 1, x, 0, "aluwb_i");
    // FETCH stalls 15 cycles: timeout trap, sticky even with mem_ready back.
    for (int i = 0; i < 15; i++)
      step(0, IT, 3'b000, 0, 0, v(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0,0), 1, x, 0, "fetch_wait15");
    trp = v(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1,0,1);
    step(0, IT, 3'b000, 0, 1, trp, 1, x, 0, "trap_mem_err_c1");
    step(0, IT, 3'b000, 0, 1, trp, 1, x, 0, "trap_mem_err_c2");
    // JALR enabled vs disabled.
    x = v(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0,0);
    step(1, JR, 3'b000, 0, 1, x, 1, x, 1, "reset_clears_trap");
    x = v(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0,0);
    step(0, JR, 3'b000, 0, 1, x, 1, x, 1, "fetch_jalr");
    x = v(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0,0);
    step(0, JR, 3'b000, 0, 1, x, 1, x, 1, "decode_jalr");
    trp = v(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1,1,0);
    step(0, JR, 3'b000, 0, 1, v(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0,0,0), 1, trp, 1, "jalr");
    step(0, JR, 3'b000, 0, 1, v(1,0,0,0,0,2'b00,2'b01,2'b10,2'b00,3'b000,0,0,0), 1, trp, 1, "jal_after_jalr");
    step(0, JR, 3'b000, 0, 1, v(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0,0,0), 1, trp, 1, "aluwb_jalr");
    step(0, JR, 3'b000, 0, 1, v(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0,0), 1, trp, 1, "fetch_after_jalr");
    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
